// File: rtl/irrigation_sequencer.sv
// rtl/irrigation_sequencer.sv - fill / water / clean tank sequencer driven by one shared tick prescaler
// Each phase counts its own divider; ticks move the tank level and end the phase.
module irrigation_sequencer #(
   parameter int FILL_DIV  = 8,
   parameter int SPR_DIV   = 4,
   parameter int DRIP_DIV  = 16,
   parameter int CLEAN_DIV = 2,
   parameter int LEVEL_MAX = 14
) (
   input  logic       clk,
   input  logic       init,
   input  logic       start,
   input  logic       stop,
   input  logic       mode_sel,
   output logic [1:0] state,
   output logic       fill_clk,
   output logic       sprinkler_clk,
   output logic       drip_clk,
   output logic       clean_done,
   output logic [3:0] level,
   output logic       busy
);

   localparam int MAX_AB  = (FILL_DIV > SPR_DIV) ? FILL_DIV : SPR_DIV;
   localparam int MAX_CD  = (DRIP_DIV > CLEAN_DIV) ? DRIP_DIV : CLEAN_DIV;
   localparam int MAX_DIV = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
   localparam int CW      = (MAX_DIV > 2) ? $clog2(MAX_DIV) : 1;
   localparam logic [3:0] LMAX = 4'(LEVEL_MAX);

   typedef enum logic [2:0] {S_IDLE, S_FILL, S_SPRINKLE, S_DRIP, S_CLEAN} phase_t;

   phase_t        cur, nxt;
   logic [CW-1:0] cnt, cnt_nxt, cnt_last;
   logic [3:0]    level_nxt;
   logic          mode, mode_nxt, tick;

   always_ff @(posedge clk or negedge init) begin
      if (!init) begin
         cur           <= S_IDLE;
         cnt           <= '0;
         level         <= '0;
         mode          <= 1'b0;
         fill_clk      <= 1'b0;
         sprinkler_clk <= 1'b0;
         drip_clk      <= 1'b0;
         clean_done    <= 1'b0;
      end else begin
         cur           <= nxt;
         cnt           <= cnt_nxt;
         level         <= level_nxt;
         mode          <= mode_nxt;
         fill_clk      <= tick && (cur == S_FILL);
         sprinkler_clk <= tick && (cur == S_SPRINKLE);
         drip_clk      <= tick && (cur == S_DRIP);
         clean_done    <= tick && (cur == S_CLEAN);
      end
   end

   always_comb begin
      nxt       = cur;
      level_nxt = level;
      mode_nxt  = mode;
      cnt_last  = '0;
      case (cur)
         S_FILL:     cnt_last = CW'(FILL_DIV - 1);
         S_SPRINKLE: cnt_last = CW'(SPR_DIV - 1);
         S_DRIP:     cnt_last = CW'(DRIP_DIV - 1);
         S_CLEAN:    cnt_last = CW'(CLEAN_DIV - 1);
         default:    cnt_last = '0;
      endcase
      tick = (cur != S_IDLE) && (cnt == cnt_last);

      // stop wins over a coincident tick: the pulse still goes out, the level does not move
      case (cur)
         S_IDLE: begin
            if (start) begin
               nxt      = S_FILL;
               mode_nxt = mode_sel;
            end
         end
         S_FILL: begin
            if (stop) begin
               nxt = S_CLEAN;
            end else if (tick) begin
               if (level >= LMAX - 4'd1) begin
                  level_nxt = LMAX;
                  nxt       = mode ? S_DRIP : S_SPRINKLE;
               end else begin
                  level_nxt = level + 4'd1;
               end
            end
         end
         S_SPRINKLE, S_DRIP: begin
            if (stop) begin
               nxt = S_CLEAN;
            end else if (tick) begin
               if (level <= 4'd1) begin
                  level_nxt = 4'd0;
                  nxt       = S_CLEAN;
               end else begin
                  level_nxt = level - 4'd1;
               end
            end
         end
         S_CLEAN: begin
            if (tick) begin
               if (level == 4'd0) nxt = S_IDLE;
               else               level_nxt = level - 4'd1;
            end
         end
         default: nxt = S_IDLE;
      endcase

      if (cur == S_IDLE || nxt != cur || tick) cnt_nxt = '0;
      else                                     cnt_nxt = cnt + 1'b1;
   end

   always_comb begin
      state = 2'b00;
      busy  = 1'b1;
      case (cur)
         S_IDLE:     busy  = 1'b0;
         S_SPRINKLE: state = 2'b01;
         S_DRIP:     state = 2'b11;
         S_CLEAN:    state = 2'b10;
         default:    state = 2'b00;
      endcase
   end

endmodule

// File: doc/irrigation_sequencer.md
IRRIGATION_SEQUENCER -- requirements
Module: irrigation_sequencer

Interface
REQ-001 SHALL have parameter FILL_DIV, default 8, clk cycles per fill tick.
REQ-002 SHALL have parameter SPR_DIV, default 4, clk cycles per sprinkler tick.
REQ-003 SHALL have parameter DRIP_DIV, default 16, clk cycles per drip tick.
REQ-004 SHALL have parameter CLEAN_DIV, default 2, clk cycles per clean tick.
REQ-005 SHALL have parameter LEVEL_MAX, default 14, full-tank level (one unit per line bit of the display stage).
REQ-006 clk  input  1  single system clock; all state changes on rising edge.
REQ-007 init  input  1  asynchronous, active-low reset.
REQ-008 start  input  1  level-sensitive request to begin a cycle; sampled only in IDLE.
REQ-009 stop  input  1  level-sensitive abort; sampled in FILL, SPRINKLE, DRIP.
REQ-010 mode_sel  input  1  watering method, 0 = sprinkler, 1 = drip; latched when start is accepted.
REQ-011 state  output  2  phase code to the display stage: 00 idle/fill, 01 sprinkler, 11 drip, 10 clean.
REQ-012 fill_clk, sprinkler_clk, drip_clk  output  1 each  one-clk-wide tick pulses.
REQ-013 clean_done  output  1  one-clk-wide clean tick pulse.
REQ-014 level  output  4  current tank level, 0..LEVEL_MAX.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 SHALL implement internal states IDLE, FILL, SPRINKLE, DRIP, CLEAN; state output = 00 for IDLE and FILL, 01 SPRINKLE, 11 DRIP, 10 CLEAN.
REQ-017 SHALL use one shared prescaler counter, cleared to 0 on every state entry, incrementing each clk; reaching DIV-1 of the active state generates a tick and wraps to 0, so the first tick occurs DIV cycles after entry.
REQ-018 SHALL drive only the tick output belonging to the current state (FILL->fill_clk, SPRINKLE->sprinkler_clk, DRIP->drip_clk, CLEAN->clean_done); all other ticks stay 0; no ticks in IDLE.
REQ-019 IDLE: start=1 -> FILL next cycle, mode_sel latched; prescaler held at 0; level unchanged.
REQ-020 FILL: each fill tick increments level; the tick that takes level to LEVEL_MAX transitions to SPRINKLE (latched mode 0) or DRIP (latched mode 1) in the same edge.
REQ-021 FILL entered with level already LEVEL_MAX: SHALL still wait for one fill tick, level saturates (no increment past LEVEL_MAX), then transition per REQ-020.
REQ-022 SPRINKLE/DRIP: each tick decrements level; the tick that takes level to 0 transitions to CLEAN.
REQ-023 stop=1 in FILL, SPRINKLE or DRIP SHALL transition to CLEAN next edge, level unchanged; stop takes priority over a coincident tick (tick pulse still emitted, level update suppressed).
REQ-024 CLEAN: each clean tick pulses clean_done; if level>0 it decrements; if level==0 at the tick, transition to IDLE.
REQ-025 level SHALL never wrap: no decrement below 0, no increment above LEVEL_MAX.
REQ-026 start and stop outside their sampling states SHALL be ignored; start held high in IDLE after CLEAN completes SHALL begin a new cycle.
REQ-027 all outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-028 init=0 SHALL asynchronously force IDLE, level=0, prescaler=0, latched mode=0, state=00, all ticks=0, busy=0, regardless of current operation.
REQ-029 after init deasserts, first state change SHALL occur no earlier than the next rising clk edge.

Verification
REQ-030 reset, start=1 mode_sel=0 one cycle -> FILL; fill_clk every 8 cycles; level 0->14 after 14 ticks (112 cycles); state becomes 01 on the 14th tick edge.
REQ-031 continue REQ-030 -> sprinkler_clk every 4 cycles, level 14->0 in 56 cycles, state 10; clean_done after 2 cycles, state 00 and busy=0 on that tick.
REQ-032 start with mode_sel=1, toggle mode_sel during FILL -> DRIP entered (state 11), drip_clk period 16, no sprinkler_clk pulses.
REQ-033 stop=1 in DRIP at level 9 -> CLEAN; 9 clean_done pulses decrement to 0, 10th pulse returns IDLE (20 cycles total).
REQ-034 init=0 mid-SPRINKLE at level 7 -> same cycle state=00, level=0, ticks=0; no activity until new start.
REQ-035 stop coincident with the 5th fill tick -> fill_clk pulses, level stays 4, state 10 next edge.
